// File: rtl/bitcoin_pwr_seq.sv
// bitcoin_pwr_seq: orders clock-stop, isolation, retention and switch steps for bit_coin.
// Define BITCOIN_PWR_STATS_EN to add the sleep_cycles/sleep_count counters.
module bitcoin_pwr_seq #(
  parameter int NUM_DOM = 4,
  parameter int ISO_DLY = 4,
  parameter int RET_DLY = 8,
  parameter int ACK_TMO = 256
) (
  input  logic               hclk,
  input  logic               reset,
  input  logic               sleep_req,
  input  logic               wake_req,
  input  logic [NUM_DOM-1:0] dom_mask,
  input  logic [NUM_DOM-1:0] power_ack_signals,
  output logic [NUM_DOM-1:0] sleep_signals,
  output logic [NUM_DOM-1:0] isolation_signals,
  output logic [NUM_DOM-1:0] retention_signals,
  output logic               lp_enable,
  output logic               busy,
  output logic               pwr_err,
`ifdef BITCOIN_PWR_STATS_EN
  output logic [31:0]        sleep_cycles,
  output logic [15:0]        sleep_count,
`endif
  output logic [3:0]         cur_state
);

  typedef enum logic [3:0] {
    ST_ACTIVE   = 4'd0,
    ST_CLK_STOP = 4'd1,
    ST_ISO_ON   = 4'd2,
    ST_SAVE     = 4'd3,
    ST_PWR_OFF  = 4'd4,
    ST_SLEEP    = 4'd5,
    ST_PWR_ON   = 4'd6,
    ST_RESTORE  = 4'd7,
    ST_ISO_OFF  = 4'd8,
    ST_CLK_RUN  = 4'd9,
    ST_ERROR    = 4'd15
  } state_t;

  localparam int MAX1 = (ISO_DLY > RET_DLY) ? ISO_DLY : RET_DLY;
  localparam int MAXV = (MAX1 > ACK_TMO) ? MAX1 : ACK_TMO;
  localparam int CW   = $clog2(MAXV);

  state_t             state_q, state_d;
  logic [NUM_DOM-1:0] mask_q, mask_d;
  logic [NUM_DOM-1:0] ack_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_DOM-1:0] slp_q, slp_d;
  logic [NUM_DOM-1:0] iso_q, iso_d;
  logic [NUM_DOM-1:0] ret_q, ret_d;
  logic               lp_q, lp_d;
  logic               err_q;
  logic               cnt_zero, ack_all, ack_none;

  // Counter holds the remaining cycles of the current state, minus one.
  function automatic logic [CW-1:0] hold_of(state_t s);
    case (s)
      ST_ISO_ON, ST_ISO_OFF: hold_of = CW'(ISO_DLY - 1);
      ST_SAVE, ST_RESTORE:   hold_of = CW'(RET_DLY - 1);
      ST_PWR_OFF, ST_PWR_ON: hold_of = CW'(ACK_TMO - 1);
      default:               hold_of = '0;
    endcase
  endfunction

  assign cnt_zero = (cnt_q == '0);
  assign ack_all  = ((ack_q & mask_q) == mask_q);
  assign ack_none = ((ack_q & mask_q) == '0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    unique case (state_q)
      ST_ACTIVE: begin
        if (sleep_req && !wake_req && (|dom_mask)) begin
          state_d = ST_CLK_STOP;
          mask_d  = dom_mask;
        end
      end
      ST_CLK_STOP: if (cnt_zero) state_d = ST_ISO_ON;
      ST_ISO_ON:   if (cnt_zero) state_d = ST_SAVE;
      ST_SAVE:     if (cnt_zero) state_d = ST_PWR_OFF;
      ST_PWR_OFF: begin
        if (ack_all)       state_d = ST_SLEEP;
        else if (cnt_zero) state_d = ST_ERROR;
      end
      ST_SLEEP:    if (wake_req) state_d = ST_PWR_ON;
      ST_PWR_ON: begin
        if (ack_none)      state_d = ST_RESTORE;
        else if (cnt_zero) state_d = ST_ERROR;
      end
      ST_RESTORE:  if (cnt_zero) state_d = ST_ISO_OFF;
      ST_ISO_OFF:  if (cnt_zero) state_d = ST_CLK_RUN;
      ST_CLK_RUN: begin
        state_d = ST_ACTIVE;
        mask_d  = '0;
      end
      ST_ERROR:    state_d = ST_ERROR;
      default:     state_d = ST_ACTIVE;
    endcase
    if (state_d != state_q) cnt_d = hold_of(state_d);
  end

  // Outputs are registered from the next state; ERROR keeps what it entered with.
  always_comb begin
    slp_d = '0;
    iso_d = '0;
    ret_d = '0;
    lp_d  = 1'b0;
    unique case (state_d)
      ST_ACTIVE, ST_CLK_RUN: lp_d = 1'b1;
      ST_ISO_ON, ST_RESTORE: iso_d = mask_d;
      ST_SAVE, ST_PWR_ON: begin
        iso_d = mask_d;
        ret_d = mask_d;
      end
      ST_PWR_OFF, ST_SLEEP: begin
        iso_d = mask_d;
        ret_d = mask_d;
        slp_d = mask_d;
      end
      ST_ERROR: begin
        slp_d = slp_q;
        iso_d = iso_q;
        ret_d = ret_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q <= ST_ACTIVE;
      mask_q  <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      slp_q   <= '0;
      iso_q   <= '0;
      ret_q   <= '0;
      lp_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ack_q   <= power_ack_signals;
      cnt_q   <= cnt_d;
      slp_q   <= slp_d;
      iso_q   <= iso_d;
      ret_q   <= ret_d;
      lp_q    <= lp_d;
      err_q   <= err_q | (state_d == ST_ERROR);
    end
  end

`ifdef BITCOIN_PWR_STATS_EN
  logic [31:0] scyc_q;
  logic [15:0] scnt_q;

  always_ff @(posedge hclk) begin
    if (reset) begin
      scyc_q <= '0;
      scnt_q <= '0;
    end else begin
      if (state_q == ST_SLEEP && !(&scyc_q)) scyc_q <= scyc_q + 1'b1;
      if (state_d == ST_SLEEP && state_q != ST_SLEEP && !(&scnt_q))
        scnt_q <= scnt_q + 1'b1;
    end
  end

  assign sleep_cycles = scyc_q;
  assign sleep_count  = scnt_q;
`endif

  assign sleep_signals     = slp_q;
  assign isolation_signals = iso_q;
  assign retention_signals = ret_q;
  assign lp_enable         = lp_q;
  assign pwr_err           = err_q;
  assign busy              = !(state_q == ST_ACTIVE || state_q == ST_SLEEP);
  assign cur_state         = state_q;

endmodule

// File: doc/bitcoin_pwr_seq.md
Name: bitcoin_pwr_seq

Overview:
Power-mode sequencer that sits directly upstream of bit_coin and drives its low-power control pins (sleep_signals, isolation_signals, retention_signals, plus the lp_enable clock/valid gate) from simple sleep/wake requests. It orders clock-stop, isolation, retention and power-switch steps per selected domain. It waits on bit_coin's power_ack_signals before advancing, and flags a timeout if an ack never arrives.

Parameters:
NUM_DOM, 4, number of switchable power domains; width of all per-domain vectors
ISO_DLY, 4, hclk cycles held after isolation changes before the next step
RET_DLY, 8, hclk cycles held after retention changes before the next step
ACK_TMO, 256, maximum hclk cycles to wait for power_ack to match sleep; must be ≥ 2

Ports:
hclk  input  1  clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
sleep_req  input  1  single-cycle pulse: begin power-down of the domains in dom_mask
wake_req  input  1  single-cycle pulse: begin power-up of the sleeping domains
dom_mask  input  NUM_DOM  domains to power down; sampled only when sleep_req is accepted
power_ack_signals  input  NUM_DOM  bit_coin switch ack; 1 = domain off
sleep_signals  output  NUM_DOM  1 = switch domain off
isolation_signals  output  NUM_DOM  1 = clamps on
retention_signals  output  NUM_DOM  1 = save/hold retention state
lp_enable  output  1  1 = hclk/lclk/data_valid to bit_coin ungated
busy  output  1  1 in any state other than ACTIVE and SLEEP
pwr_err  output  1  sticky ack-timeout flag
cur_state  output  4  encoded FSM state, for debug

Behaviour:
- Reset values: all vectors 0, lp_enable=1, busy=0, pwr_err=0, state ACTIVE. Reset mid-sequence returns to ACTIVE immediately. Under UPF, reset is applied only with domains powered.
- mask_q (NUM_DOM) latches dom_mask on sleep_req acceptance. Per-domain outputs only ever assert for bits set in mask_q.
- States, in order:
  - ACTIVE (0):
    - sleep_req=1 and dom_mask≠0: latch mask, go to CLK_STOP.
    - sleep_req with dom_mask=0: ignored.
    - wake_req: ignored.
    - sleep_req and wake_req in the same cycle: wake wins, stay ACTIVE.
  - CLK_STOP (1): lp_enable=0 for 1 cycle, then ISO_ON.
  - ISO_ON (2): isolation=mask_q; hold ISO_DLY cycles, then SAVE.
  - SAVE (3): retention=mask_q; hold RET_DLY cycles, then PWR_OFF.
  - PWR_OFF (4): sleep=mask_q. Wait until (power_ack & mask_q)==mask_q, then SLEEP. If ACK_TMO cycles elapse first, go to ERROR.
  - SLEEP (5):
    - Outputs held; lp_enable=0.
    - wake_req=1: go to PWR_ON.
    - sleep_req: ignored.
  - PWR_ON (6): sleep=0. Wait until (power_ack & mask_q)==0, else time out to ERROR after ACK_TMO cycles.
  - RESTORE (7): retention=0; hold RET_DLY cycles, then ISO_OFF.
  - ISO_OFF (8): isolation=0; hold ISO_DLY cycles, then CLK_RUN.
  - CLK_RUN (9): lp_enable=1; next cycle go to ACTIVE and clear mask_q.
  - ERROR (15):
    - pwr_err=1 (sticky until reset).
    - Outputs frozen at their values on entry; lp_enable=0; busy=1.
    - Exits only via reset.
- One shared down-counter: loaded on every state entry, decrements each cycle, and the transition fires when it reaches 0. A hold of D cycles means exactly D cycles in that state.
- Ack comparison uses the registered power_ack, so the transition occurs one cycle after the ack matches.
- Requests arriving while busy=1 are dropped; there is no queueing.
- Unmasked domain bits are always 0 on every output.
- Ack bits outside mask_q are ignored.

Optional Feature:
BITCOIN_PWR_STATS_EN:
- When defined, adds outputs sleep_cycles (32-bit) and sleep_count (16-bit).
  - sleep_cycles increments every cycle in SLEEP, saturating at all-ones.
  - sleep_count increments on each SLEEP entry, saturating.
  - Both reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Power-down: dom_mask=4'b0101, sleep_req pulse at cycle 10, ack mirrors sleep after 3 cycles.
   → lp_enable=0 at cycle 11, isolation=0101 at cycle 12, retention=0101 at cycle 16, sleep=0101 at cycle 24, SLEEP reached at cycle 28 with busy=0.
2. Wake from the state of test 1: wake_req pulse, ack drops after 2 cycles.
   → sleep=0, then retention=0 and isolation=0 in order after RET_DLY and ISO_DLY holds; lp_enable=1 in CLK_RUN; ACTIVE reached with all vectors 0.
3. Timeout: power_ack stuck at 0 during PWR_OFF.
   → ERROR after 256 cycles, pwr_err=1, sleep/isolation/retention frozen at 0101; only reset clears it.
4. Simultaneous sleep_req=1 and wake_req=1 in ACTIVE → no state change. Separately, sleep_req with dom_mask=0 → ignored.
5. Reset asserted in SAVE → next cycle all vectors 0, lp_enable=1, state ACTIVE. Separately, sleep_req pulsed during ISO_ON → dropped, and mask_q unchanged.
6. With BITCOIN_PWR_STATS_EN defined: two sleeps of 50 and 30 cycles → sleep_count=2, sleep_cycles=80.
